// File: rtl/equiv_pkg.sv
// Shared types and helpers for the exhaustive equivalence checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package equiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of the dwell counter: enough bits for 0..dwell-1, never zero bits.
  function automatic int ctr_w(input int dwell);
    return (dwell <= 1) ? 1 : $clog2(dwell);
  endfunction

endpackage

// File: rtl/equiv_sweep_ctr.sv
// Dwell counter plus stimulus counter; flags the compare cycle and the last vector.
// Latency: cmp_now/last_vec are combinational from the counter registers.
// Backpressure: en low freezes both counters; clr zeroes them and wins over en.
module equiv_sweep_ctr #(
  parameter int IN_W  = 2,
  parameter int DWELL = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  output logic [IN_W-1:0] stim,
  output logic            cmp_now,
  output logic            last_vec
);
  import equiv_pkg::*;

  localparam int            CW       = ctr_w(DWELL);
  localparam logic [CW-1:0] LAST_CNT = CW'(DWELL - 1);

  logic [CW-1:0] dwell_cnt;

  // cmp_now is not gated by en so the owner can use it to decide whether to advance.
  assign cmp_now  = (dwell_cnt == LAST_CNT);
  assign last_vec = (stim == {IN_W{1'b1}});

  // Count dwell cycles; on the final one step to the next vector.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      dwell_cnt <= '0;
      stim      <= '0;
    end else if (en) begin
      if (cmp_now) begin
        dwell_cnt <= '0;
        stim      <= stim + IN_W'(1);
      end else begin
        dwell_cnt <= dwell_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/exhaustive_equiv_checker.sv
// Sweeps every IN_W-bit vector, compares two combinational DUTs, keeps mismatch count and first failing vector.
// Latency: full sweep takes 2^IN_W*DWELL cycles from the edge that accepts start; results update one edge after each compare.
// Backpressure: none; start is ignored while busy. Build option EQUIV_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module exhaustive_equiv_checker #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 1,
  parameter int DWELL = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IN_W-1:0]  stim,
  input  logic [OUT_W-1:0] out_a,
  input  logic [OUT_W-1:0] out_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IN_W:0]    mismatch_cnt,
  output logic             fail_valid,
  output logic [IN_W-1:0]  fail_vec
);
  import equiv_pkg::*;

  state_t state, state_nxt;
  logic   run, start_acc, cmp_now, last_vec, cmp, mismatch, finish, ctr_en;

  assign run       = (state == ST_RUN);
  assign start_acc = start && !run;
  assign cmp       = run && cmp_now;
  assign mismatch  = (out_a != out_b);

`ifdef EQUIV_STOP_ON_FAIL_EN
  assign finish = cmp && (last_vec || mismatch);
`else
  assign finish = cmp && last_vec;
`endif

  // Freezing the counters on the finishing compare leaves stim on the final vector.
  assign ctr_en = run && !finish;

  assign busy = run;
  assign done = (state == ST_DONE);
  assign pass = done && (mismatch_cnt == '0);

  equiv_sweep_ctr #(
    .IN_W  (IN_W),
    .DWELL (DWELL)
  ) u_sweep_ctr (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_acc),
    .en       (ctr_en),
    .stim     (stim),
    .cmp_now  (cmp_now),
    .last_vec (last_vec)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: start launches a sweep from IDLE or DONE, finishing compare ends it.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)  state_nxt = ST_RUN;
      ST_RUN:  if (finish) state_nxt = ST_DONE;
      ST_DONE: if (start)  state_nxt = ST_RUN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Result registers: cleared on accepted start, updated on mismatching compares.
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      mismatch_cnt <= '0;
      fail_valid   <= 1'b0;
      fail_vec     <= '0;
    end else if (cmp && mismatch) begin
      mismatch_cnt <= mismatch_cnt + (IN_W+1)'(1);
      if (!fail_valid) begin
        fail_valid <= 1'b1;
        fail_vec   <= stim;
      end
    end
  end

endmodule

// File: tb/tb_exhaustive_equiv_checker.sv
// Bench for exhaustive_equiv_checker: two instances (IN_W=2/DWELL=10 and IN_W=4/DWELL=1) driven by truth tables.
// Latency: expectations derived from a vector-by-vector model of the sweep.
// Backpressure: n/a.
module tb_exhaustive_equiv_checker;

  logic clk;
  logic rst, start2, start4;
  logic [15:0] ta, tb;

  logic [1:0] stim2;
  logic       a2, b2, busy2, done2, pass2, fv2;
  logic [2:0] cnt2;
  logic [1:0] fvec2;

  logic [3:0] stim4;
  logic       a4, b4, busy4, done4, pass4, fv4;
  logic [4:0] cnt4;
  logic [3:0] fvec4;

  int n_chk, n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign a2 = ta[stim2];
  assign b2 = tb[stim2];
  assign a4 = ta[stim4];
  assign b4 = tb[stim4];

  exhaustive_equiv_checker #(.IN_W(2), .OUT_W(1), .DWELL(10)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .stim(stim2), .out_a(a2), .out_b(b2),
    .busy(busy2), .done(done2), .pass(pass2), .mismatch_cnt(cnt2),
    .fail_valid(fv2), .fail_vec(fvec2)
  );

  exhaustive_equiv_checker #(.IN_W(4), .OUT_W(1), .DWELL(1)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .stim(stim4), .out_a(a4), .out_b(b4),
    .busy(busy4), .done(done4), .pass(pass4), .mismatch_cnt(cnt4),
    .fail_valid(fv4), .fail_vec(fvec4)
  );

  // Observation mux so one set of checks serves both instances.
  logic        sel;
  logic [31:0] obs_stim, obs_cnt, obs_fvec;
  logic        obs_busy, obs_done, obs_pass, obs_fv;

  always_comb begin
    obs_stim = sel ? 32'(stim4) : 32'(stim2);
    obs_cnt  = sel ? 32'(cnt4)  : 32'(cnt2);
    obs_fvec = sel ? 32'(fvec4) : 32'(fvec2);
    obs_busy = sel ? busy4 : busy2;
    obs_done = sel ? done4 : done2;
    obs_pass = sel ? pass4 : pass2;
    obs_fv   = sel ? fv4   : fv2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic check_reset(input bit s, input string tag);
    sel = s;
    #1;
    check({tag, "_stim"}, obs_stim, 0);
    check({tag, "_busy"}, 32'(obs_busy), 0);
    check({tag, "_done"}, 32'(obs_done), 0);
    check({tag, "_pass"}, 32'(obs_pass), 0);
    check({tag, "_cnt"},  obs_cnt, 0);
    check({tag, "_fv"},   32'(obs_fv), 0);
    check({tag, "_fvec"}, obs_fvec, 0);
  endtask

  task automatic set_start(input bit s, input logic v);
    if (s) start4 = v;
    else   start2 = v;
  endtask

  // Run one sweep on the selected instance; poke_at > 0 pulses start mid-sweep.
  task automatic run_sweep(input bit s, input int poke_at, input string tag);
    int n, dw, exp_cnt, exp_first, exp_end, lat, done_at;
    bit exp_fv;
    n  = s ? 16 : 4;
    dw = s ? 1 : 10;
    exp_cnt = 0; exp_first = 0; exp_fv = 1'b0; exp_end = n - 1;
    for (int v = 0; v < n; v++) begin
      if (ta[v] != tb[v]) begin
        exp_cnt++;
        if (!exp_fv) begin
          exp_fv    = 1'b1;
          exp_first = v;
        end
`ifdef EQUIV_STOP_ON_FAIL_EN
        exp_end = v;
        break;
`endif
      end
    end
    lat = (exp_end + 1) * dw;

    sel = s;
    @(negedge clk);
    set_start(s, 1'b1);
    @(posedge clk);
    #1;
    set_start(s, 1'b0);
    check({tag, "_busy_k"}, 32'(obs_busy), 1);
    check({tag, "_stim_k"}, obs_stim, 0);
    check({tag, "_done_k"}, 32'(obs_done), 0);
    check({tag, "_cnt_k"},  obs_cnt, 0);

    done_at = -1;
    for (int c = 1; c <= lat + 20; c++) begin
      @(posedge clk);
      #1;
      set_start(s, 1'b0);
      if (obs_done) begin
        done_at = c;
        break;
      end
      if (c % dw == 0) check({tag, "_stim_step"}, obs_stim, 32'(c / dw));
      if (c == poke_at && c < lat - 1) set_start(s, 1'b1);
    end

    check({tag, "_done_cycle"}, 32'(done_at), 32'(lat));
    check({tag, "_busy_end"}, 32'(obs_busy), 0);
    check({tag, "_pass"}, 32'(obs_pass), 32'(exp_cnt == 0));
    check({tag, "_cnt"},  obs_cnt, 32'(exp_cnt));
    check({tag, "_fv"},   32'(obs_fv), 32'(exp_fv));
    check({tag, "_fvec"}, obs_fvec, 32'(exp_first));
    check({tag, "_stim_end"}, obs_stim, 32'(exp_end));
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_hold_done"}, 32'(obs_done), 1);
    check({tag, "_hold_cnt"},  obs_cnt, 32'(exp_cnt));
    check({tag, "_hold_stim"}, obs_stim, 32'(exp_end));
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1; start2 = 1'b0; start4 = 1'b0; sel = 1'b0;
    ta = '0; tb = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset(1'b0, "rst2");
    check_reset(1'b1, "rst4");
    rst = 1'b0;

    // Identical XOR gates, with a start pulse mid-sweep that must be ignored.
    ta = 16'h0006; tb = 16'h0006;
    run_sweep(1'b0, 15, "xor");

    // AND versus OR: vectors 1 and 2 differ.
    ta = 16'h0008; tb = 16'h000E;
    run_sweep(1'b0, -1, "andor");

    // Four-bit sweep, B differs only at vector 15.
    ta = 16'($urandom); tb = ta ^ 16'h8000;
    run_sweep(1'b1, 5, "inv15");

    // Every vector mismatches: count reaches 2^IN_W without wrapping.
    ta = 16'($urandom); tb = ~ta;
    run_sweep(1'b1, -1, "allbad");

    // Abort a sweep with reset at cycle 25, then sweep again.
    ta = 16'h0008; tb = 16'h000E;
    sel = 1'b0;
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    repeat (24) @(posedge clk);
    #1;
    check("abort_fv_before", 32'(fv2), 1);
    rst = 1'b1;
    @(posedge clk);
    check_reset(1'b0, "abort");
    rst = 1'b0;
    run_sweep(1'b0, 7, "after_rst");

    // Random truth tables with sparse differences on both instances.
    for (int i = 0; i < 4; i++) begin
      ta = 16'($urandom);
      tb = ta ^ 16'($urandom & $urandom & $urandom);
      run_sweep(1'b0, -1, "rand2");
      run_sweep(1'b1, -1, "rand4");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
